// File: rtl/booth_pkg.sv
// Shared types for the iterative radix-4 Booth multiplier: FSM states,
// per-digit control word and the digit-count helper.
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Booth digit as sign plus one-hot magnitude: {0, ±1, ±2}
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } digit_ctrl_t;

    // One extra digit beyond WIDTH/2 absorbs the top bit of unsigned operands
    function automatic int booth_n_dig(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Radix-4 Booth recoder: 3-bit multiplier window to {neg, one, two}.
// Purely combinational; the multiplier top reuses a single instance every cycle.
module booth_digit_enc
    import booth_pkg::*;
(
    input  logic [2:0]  window_i,
    output digit_ctrl_t ctrl_o
);

    always_comb begin
        ctrl_o.neg = window_i[2] & ~(window_i[1] & window_i[0]);
        ctrl_o.one = window_i[1] ^ window_i[0];
        ctrl_o.two = (window_i == 3'b011) | (window_i == 3'b100);
    end

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
// Define BOOTH_EARLY_TERM_EN to finish as soon as all remaining digits are zero.
module booth_mul_iter
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N_DIG = booth_n_dig(WIDTH);
    localparam int ACC_W = 2 * WIDTH + 2;
    localparam int MP_W  = WIDTH + 3;
    localparam int CNT_W = $clog2(N_DIG + 1);

    state_t                    state_q;
    logic signed [ACC_W-1:0]   mcand_q;
    logic signed [MP_W-1:0]    mplier_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic        [CNT_W-1:0]   cnt_q;
    logic        [2*WIDTH-1:0] product_q;
    logic                      in_ready_q;
    logic                      out_valid_q;

    digit_ctrl_t               dig;
    logic signed [ACC_W-1:0]   pp;
    logic signed [ACC_W-1:0]   acc_d;
    logic signed [ACC_W-1:0]   mcand_d;
    logic signed [MP_W-1:0]    mplier_d;
    logic                      last_d;

    // Multiplicand is held at accumulator width so its left shifts never lose bits
    function automatic logic signed [ACC_W-1:0] ext_mcand(input logic [WIDTH-1:0] v,
                                                          input logic              sgn);
        return {{(ACC_W-WIDTH){sgn & v[WIDTH-1]}}, v};
    endfunction

    function automatic logic signed [MP_W-1:0] ext_mplier(input logic [WIDTH-1:0] v,
                                                          input logic              sgn);
        logic e;
        e = sgn & v[WIDTH-1];
        return {e, e, v, 1'b0};
    endfunction

    booth_digit_enc u_enc (
        .window_i (mplier_q[2:0]),
        .ctrl_o   (dig)
    );

    always_comb begin
        pp       = '0;
        if (dig.two)
            pp = mcand_q <<< 1;
        else if (dig.one)
            pp = mcand_q;
        acc_d    = dig.neg ? (acc_q - pp) : (acc_q + pp);
        mcand_d  = mcand_q <<< 2;
        mplier_d = mplier_q >>> 2;
        last_d   = (cnt_q == CNT_W'(N_DIG - 1));
`ifdef BOOTH_EARLY_TERM_EN
        // Remaining window bits (lookback included) all equal means only zero digits are left
        last_d   = last_d | (mplier_d == '0) | (&mplier_d);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        mcand_q    <= ext_mcand(a, is_signed);
                        mplier_q   <= ext_mplier(b, is_signed);
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_d) begin
                        product_q   <= acc_d[2*WIDTH-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule
